// File: rtl/demux_deser.sv
// demux_deser: serial-to-parallel distributor.
// Accepts one bit per cycle, steers it to bit position SEL of an assembly
// register, and hands completed words to a double-buffered output stage.
// Bit k of a word (k-th accepted bit) lands in Z[k].
module demux_deser #(
  parameter  int N_BITS = 64,
  localparam int SEL_W  = $clog2(N_BITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              I,
  input  logic              I_VALID,
  output logic              I_READY,
  input  logic              CLR,
  output logic [SEL_W-1:0]  SEL,
  output logic [N_BITS-1:0] Z,
  output logic              Z_VALID,
  input  logic              Z_READY
);

  // Assembly register holds bits 0..N_BITS-2; the final bit goes straight
  // into Z together with them, so bit N_BITS-1 never needs storage here.
  logic [N_BITS-2:0] asm_q;
  // Low during reset and for the first edge after release, keeping I_READY
  // low until the block has seen a clock.
  logic              live_q;
  logic              last_pos;
  logic              accept;
  logic              consume;

  assign last_pos = (SEL == SEL_W'(N_BITS - 1));
  // Only the completing bit waits on an unconsumed output word.
  assign I_READY  = live_q && !CLR && (!last_pos || !Z_VALID || Z_READY);
  assign accept   = I_VALID && I_READY;
  assign consume  = Z_VALID && Z_READY;

  // Arm the input side on the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

  // Position counter and assembly register; CLR discards the partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SEL   <= '0;
      asm_q <= '0;
    end else if (CLR) begin
      SEL   <= '0;
      asm_q <= '0;
    end else if (accept) begin
      if (last_pos) begin
        SEL   <= '0;
        asm_q <= '0;
      end else begin
        SEL <= SEL + SEL_W'(1);
        for (int k = 0; k < N_BITS - 1; k++) begin
          if (SEL == SEL_W'(k)) begin
            asm_q[k] <= I;
          end
        end
      end
    end
  end

  // Output word stage: load on completion (even while being consumed, so
  // back-to-back words see no bubble), otherwise drop valid on consumption.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Z       <= '0;
      Z_VALID <= 1'b0;
    end else if (accept && last_pos) begin
      Z       <= {I, asm_q};
      Z_VALID <= 1'b1;
    end else if (consume) begin
      Z_VALID <= 1'b0;
    end
  end

endmodule

// File: doc/demux_deser.md
Name: demux_deser

Overview:
- Serial-to-parallel distributor: the write-side counterpart of the muxN selection trees.
- Accepts one bit per cycle over a valid/ready handshake and steers it to bit position SEL of an internal assembly register; SEL is an internal counter.
- When all N_BITS positions are filled, the word moves to a double-buffered output register and is offered downstream with a valid/ready handshake.
- Sits between a 1-bit serial source and any consumer of the N-bit words fed into the mux trees.

Parameters:
- N_BITS, 64, word width; power of two, 2..512.
- SEL_W, $clog2(N_BITS), derived width of SEL; not overridden.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- I  input  1  serial data bit.
- I_VALID  input  1  I carries a bit this cycle.
- I_READY  output  1  block accepts I this cycle (combinational).
- CLR  input  1  synchronous abort of the partially assembled word.
- SEL  output  SEL_W  bit position the next accepted bit is written to (registered).
- Z  output  N_BITS  assembled word (registered).
- Z_VALID  output  1  Z holds a complete, unconsumed word.
- Z_READY  input  1  consumer takes Z this cycle.

Behaviour:
- Reset (rst_n low, async): SEL=0, Z=0, Z_VALID=0, assembly reg A=0. I_READY=0 while rst_n is low, and reaches 1 on the first clk after release.
- Transfer: a bit is accepted when I_VALID && I_READY at a rising edge. Z/Z_VALID transfer occurs when Z_VALID && Z_READY.
- Bit order: the first bit accepted after reset/CLR/completion goes to bit 0. The k-th bit goes to Z[k], consistent with mux convention (SEL=k selects I[k]).
- Non-final bit (SEL != N_BITS-1): A[SEL] <= I, SEL <= SEL+1. Assembly continues even while Z_VALID=1 and stalled (double buffering).
- Final bit (SEL == N_BITS-1): Z <= {I, A[N_BITS-2:0]}, Z_VALID <= 1, SEL <= 0, A <= 0.
  - Latency: Z_VALID rises the cycle after the final bit is accepted.
- I_READY = !CLR && (SEL != N_BITS-1 || !Z_VALID || Z_READY). Only the completing bit is backpressured by an unconsumed output word.
- Simultaneous completion and consumption (Z_VALID && Z_READY && final bit accepted): the new word replaces Z and Z_VALID stays 1, with no bubble.
- Consumption without completion: Z_VALID <= 0; Z retains its last value.
- Output stability: while Z_VALID && !Z_READY, Z and Z_VALID hold stable.
- CLR: next edge sets SEL=0 and A=0; Z and Z_VALID are unaffected. I_READY is 0 during CLR, so a bit presented with CLR is not accepted.
  - CLR with SEL=0 is harmless.
  - CLR and Z_READY in the same cycle: the consumption still happens.
- Counter wrap: SEL wraps N_BITS-1 -> 0 only on a completing bit, and never exceeds N_BITS-1.
- Reset mid-word: all partial data is discarded and any pending Z_VALID is dropped.
- No combinational path from I to Z. The only combinational output is I_READY (from CLR, SEL, Z_VALID, Z_READY).

Test Plan:
- N_BITS=8, Z_READY=1, I_VALID=1 streaming 1,0,1,1,0,0,1,0 -> Z=8'h4D, with Z_VALID pulsing 1 cycle, one cycle after the 8th bit; SEL steps 0..7 then 0.
- Back-to-back words, Z_READY=1: stream 16 bits (8'hFF then 8'h01, LSB first) -> Z_VALID high two cycles, 8 apart. I_READY never drops.
- Backpressure: Z_READY=0 after the first word 8'hA5, then stream 8 more bits -> bits 0..6 accepted, I_READY=0 at SEL=7, Z holds 8'hA5. Raise Z_READY -> final bit accepted the same cycle, and next cycle Z=new word with Z_VALID held high.
- CLR mid-word: 3 bits accepted (SEL=3), CLR with I_VALID=1 -> bit dropped, SEL=0. The next 8 bits 8'h3C -> Z=8'h3C; the pending previous Z is unaffected.
- Async reset: assert rst_n=0 mid-cycle at SEL=5 with Z_VALID=1 -> SEL=0, Z=0, Z_VALID=0 and I_READY=0 immediately without a clock. After release, the first bit lands in Z[0].
- N_BITS=2 corner: bits 1,0 then 0,1 with Z_READY=1 -> Z=2'b01 then 2'b10. SEL toggles 0/1 each accepted bit.
